axi_lite_master: RTL and testbench
==================================

# axi_lite_master

AXI-Lite initiator that turns single-beat commands from the sort datapath into AXI-Lite read or write transactions against the team's AXI-Lite memory. It returns one response per command. It runs one transaction at a time, drives AW and W independently, and latches read data and response status. It also keeps a saturating error count for debug.

## Interface
- `ADDR_WDTH`, 4, address width (AR/AW and command address)
- `DATA_WDTH`, 32, data width (R/W and command data)
- `RESP_WDTH`, 1, response width; 0 = OKAY, 1 = error
- `ERRC_WDTH`, 8, width of the error counter
- `clk`  in  1  single clock, all logic on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  command accepted when high with `cmd_valid`
- `cmd_write`  in  1  1 = write, 0 = read
- `cmd_addr`  in  ADDR_WDTH  target address
- `cmd_wdata`  in  DATA_WDTH  write data (ignored for reads)
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  response consumed when high with `rsp_valid`
- `rsp_rdata`  out  DATA_WDTH  read data; 0 for writes
- `rsp_err`  out  1  OR-reduction of r_resp/b_resp
- `err_count`  out  ERRC_WDTH  saturating count of error responses
- `ar_valid`  out  1
- `ar_ready`  in  1
- `ar_address`  out  ADDR_WDTH
- `r_valid`  in  1
- `r_ready`  out  1
- `r_data`  in  DATA_WDTH
- `r_resp`  in  RESP_WDTH
- `aw_valid`  out  1
- `aw_ready`  in  1
- `aw_address`  out  ADDR_WDTH
- `w_valid`  out  1
- `w_ready`  in  1
- `w_data`  out  DATA_WDTH
- `b_valid`  in  1
- `b_ready`  out  1
- `b_resp`  in  RESP_WDTH

## Operation
- **States:** IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RSP.
- **IDLE:**
  - `cmd_ready` = 1.
  - On `cmd_valid`, latch addr/data/write.
  - Go to RD_ADDR (read) or WR_REQ (write).
- **RD_ADDR:**
  - `ar_valid` = 1 and `ar_address` stable.
  - On `ar_ready`, go to RD_DATA.
- **RD_DATA:**
  - `r_ready` = 1.
  - On `r_valid`, latch `r_data` and `|r_resp`, then go to RSP.
- **WR_REQ:**
  - `aw_valid` and `w_valid` are both raised on entry.
  - Flags `aw_done`/`w_done` are set on the respective handshake; each valid drops the cycle after its own handshake.
  - The two handshakes may occur in the same cycle or in either order.
  - When both are done (including on the same edge), go to WR_RESP.
- **WR_RESP:**
  - `b_ready` = 1.
  - On `b_valid`, latch `|b_resp` and set `rsp_rdata` = 0, then go to RSP.
- **RSP:**
  - `rsp_valid` = 1; outputs stay stable until `rsp_ready`, then go to IDLE.
  - No new command is accepted in the same cycle.
- **Error counter:** `err_count` increments when a response with error is latched and saturates at all-ones.
- **Early responses:** `r_valid`/`b_valid` outside RD_DATA/WR_RESP are ignored, since ready is low.
- **Handshake discipline:** a valid, once raised, never drops before its ready. Payload does not change while valid is high.
- **Reset:**
  - State returns to IDLE and all flags and counters clear.
  - Reset mid-transaction abandons the transaction, with no response emitted. The slave is reset from the same `rst_n`.
  - `cmd_ready` is 0 while `rst_n` is low.

## Timing
- **Reset values:**
  - ar/aw/w_valid, r/b_ready, rsp_valid = 0.
  - rsp_rdata, rsp_err, err_count = 0.
  - ar/aw_address, w_data = 0.
- All AXI outputs are registered or decoded from the state register only; no input-to-output combinational path exists.
- **Read, zero-wait slave:**
  - Command accepted at cycle 0; `ar_valid` at cycle 1.
  - `r_ready` at cycle 2; `rsp_valid` at cycle 3.
  - Minimum latency is 3 cycles.
- **Write, zero-wait slave:**
  - AW/W at cycle 1; `b_ready` at cycle 2; `rsp_valid` at cycle 3.
- Each wait cycle on any channel adds exactly one cycle of latency.
- **Throughput:** at most one command per 4 cycles.

## Structure
- **Shared package `axi_lite_pkg`:**
  - `RESP_OKAY` = 1'b0 and `RESP_ERR` = 1'b1.
  - State enum `axil_mst_state_t`.
  - Default widths (4/32/1), reused by the memory and by this block.
- **Sub-modules:** none; a single module of about 200 lines.

## Test plan
- **Write then read:**
  - Stimulus: write addr 0x3, data 0xDEADBEEF, then read addr 0x3, against a zero-wait OKAY memory.
  - Required: `rsp_rdata` = 0xDEADBEEF and `rsp_err` = 0.
  - Required: each `rsp_valid` appears 3 cycles after `cmd` acceptance.
- **AW/W ordering:**
  - Stimulus: `w_ready` 2 cycles before `aw_ready`, then the reverse order, then both in the same cycle.
  - Required: exactly one AW and one W handshake per write.
  - Required: WR_RESP is entered on the cycle after the later handshake.
- **Error responses:**
  - Stimulus: memory forced to error; issue 300 reads.
  - Required: `rsp_err` = 1 on every response; `err_count` saturates at 255.
- **Backpressure:**
  - Stimulus: `ar_ready` held low for 5 cycles and `rsp_ready` held low for 4 cycles.
  - Required: `ar_address` and `rsp_*` stay stable throughout.
  - Required: `cmd_ready` stays 0 until the response handshake completes.
- **Reset mid-operation:**
  - Stimulus: assert `rst_n` = 0 in WR_REQ after the AW handshake only.
  - Required: all valids/readies are 0 after the next edge, and no response is emitted.
  - Required: the next read, to addr 0x0, completes normally.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite definitions: default bus widths, response codes and the
// initiator state encoding. Imported by the AXI-Lite master and the memory.
package axi_lite_pkg;

    localparam int unsigned DFLT_ADDR_WDTH = 4;
    localparam int unsigned DFLT_DATA_WDTH = 32;
    localparam int unsigned DFLT_RESP_WDTH = 1;
    localparam int unsigned DFLT_ERRC_WDTH = 8;

    localparam logic RESP_OKAY = 1'b0;
    localparam logic RESP_ERR  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_RESP = 3'd4,
        ST_RSP     = 3'd5
    } axil_mst_state_t;

endpackage

// File: rtl/axi_lite_master.sv
// AXI-Lite initiator: converts single-beat read/write commands into one
// AXI-Lite transaction at a time and returns one response per command.
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   cmd_*                   command channel (valid/ready, write, addr, wdata)
//   rsp_*                   response channel (valid/ready, rdata, err)
//   err_count               saturating count of error responses
//   ar_*/r_*/aw_*/w_*/b_*   AXI-Lite initiator channels
module axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter int unsigned ADDR_WDTH = DFLT_ADDR_WDTH,
    parameter int unsigned DATA_WDTH = DFLT_DATA_WDTH,
    parameter int unsigned RESP_WDTH = DFLT_RESP_WDTH,
    parameter int unsigned ERRC_WDTH = DFLT_ERRC_WDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [ADDR_WDTH-1:0] cmd_addr,
    input  logic [DATA_WDTH-1:0] cmd_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DATA_WDTH-1:0] rsp_rdata,
    output logic                 rsp_err,
    output logic [ERRC_WDTH-1:0] err_count,
    output logic                 ar_valid,
    input  logic                 ar_ready,
    output logic [ADDR_WDTH-1:0] ar_address,
    input  logic                 r_valid,
    output logic                 r_ready,
    input  logic [DATA_WDTH-1:0] r_data,
    input  logic [RESP_WDTH-1:0] r_resp,
    output logic                 aw_valid,
    input  logic                 aw_ready,
    output logic [ADDR_WDTH-1:0] aw_address,
    output logic                 w_valid,
    input  logic                 w_ready,
    output logic [DATA_WDTH-1:0] w_data,
    input  logic                 b_valid,
    output logic                 b_ready,
    input  logic [RESP_WDTH-1:0] b_resp
);

    localparam logic [ERRC_WDTH-1:0] ERRC_MAX = '1;

    axil_mst_state_t state_q, state_d;

    logic                 cmd_ready_q, cmd_ready_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [DATA_WDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                 rsp_err_q,   rsp_err_d;
    logic [ERRC_WDTH-1:0] err_count_q, err_count_d;
    logic                 ar_valid_q,  ar_valid_d;
    logic [ADDR_WDTH-1:0] ar_addr_q,   ar_addr_d;
    logic                 r_ready_q,   r_ready_d;
    logic                 aw_valid_q,  aw_valid_d;
    logic [ADDR_WDTH-1:0] aw_addr_q,   aw_addr_d;
    logic                 w_valid_q,   w_valid_d;
    logic [DATA_WDTH-1:0] w_data_q,    w_data_d;
    logic                 b_ready_q,   b_ready_d;
    logic                 aw_done_q,   aw_done_d;
    logic                 w_done_q,    w_done_d;

    logic aw_hs;
    logic w_hs;
    logic err_hit;

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        err_count_d = err_count_q;
        ar_valid_d  = ar_valid_q;
        ar_addr_d   = ar_addr_q;
        r_ready_d   = r_ready_q;
        aw_valid_d  = aw_valid_q;
        aw_addr_d   = aw_addr_q;
        w_valid_d   = w_valid_q;
        w_data_d    = w_data_q;
        b_ready_d   = b_ready_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        aw_hs       = aw_valid_q & aw_ready;
        w_hs        = w_valid_q & w_ready;
        err_hit     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    cmd_ready_d = 1'b0;
                    if (cmd_write) begin
                        state_d    = ST_WR_REQ;
                        aw_valid_d = 1'b1;
                        w_valid_d  = 1'b1;
                        aw_addr_d  = cmd_addr;
                        w_data_d   = cmd_wdata;
                        aw_done_d  = 1'b0;
                        w_done_d   = 1'b0;
                    end else begin
                        state_d    = ST_RD_ADDR;
                        ar_valid_d = 1'b1;
                        ar_addr_d  = cmd_addr;
                    end
                end
            end
            ST_RD_ADDR: begin
                if (ar_ready) begin
                    state_d    = ST_RD_DATA;
                    ar_valid_d = 1'b0;
                    r_ready_d  = 1'b1;
                end
            end
            ST_RD_DATA: begin
                if (r_valid) begin
                    state_d     = ST_RSP;
                    r_ready_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = r_data;
                    rsp_err_d   = |r_resp;
                    err_hit     = |r_resp;
                end
            end
            ST_WR_REQ: begin
                // AW and W complete independently; leave once both have.
                if (aw_hs) begin
                    aw_valid_d = 1'b0;
                    aw_done_d  = 1'b1;
                end
                if (w_hs) begin
                    w_valid_d = 1'b0;
                    w_done_d  = 1'b1;
                end
                if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
                    state_d   = ST_WR_RESP;
                    b_ready_d = 1'b1;
                end
            end
            ST_WR_RESP: begin
                if (b_valid) begin
                    state_d     = ST_RSP;
                    b_ready_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = |b_resp;
                    err_hit     = |b_resp;
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                cmd_ready_d = 1'b1;
            end
        endcase

        if (err_hit && (err_count_q != ERRC_MAX)) begin
            err_count_d = err_count_q + ERRC_WDTH'(1);
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            err_count_q <= '0;
            ar_valid_q  <= 1'b0;
            ar_addr_q   <= '0;
            r_ready_q   <= 1'b0;
            aw_valid_q  <= 1'b0;
            aw_addr_q   <= '0;
            w_valid_q   <= 1'b0;
            w_data_q    <= '0;
            b_ready_q   <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            err_count_q <= err_count_d;
            ar_valid_q  <= ar_valid_d;
            ar_addr_q   <= ar_addr_d;
            r_ready_q   <= r_ready_d;
            aw_valid_q  <= aw_valid_d;
            aw_addr_q   <= aw_addr_d;
            w_valid_q   <= w_valid_d;
            w_data_q    <= w_data_d;
            b_ready_q   <= b_ready_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
        end
    end

    // Held low during reset even before the first reset edge is seen.
    assign cmd_ready  = cmd_ready_q & rst_n;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_err    = rsp_err_q;
    assign err_count  = err_count_q;
    assign ar_valid   = ar_valid_q;
    assign ar_address = ar_addr_q;
    assign r_ready    = r_ready_q;
    assign aw_valid   = aw_valid_q;
    assign aw_address = aw_addr_q;
    assign w_valid    = w_valid_q;
    assign w_data     = w_data_q;
    assign b_ready    = b_ready_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master with a small AXI-Lite memory whose
// channel ready delays and error response are controlled per test.
module tb_axi_lite_master;
    import axi_lite_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [3:0]  cmd_addr = 4'h0;
    logic [31:0] cmd_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [7:0]  err_count;
    logic        ar_valid, ar_ready;
    logic [3:0]  ar_address;
    logic        r_valid, r_ready;
    logic [31:0] r_data;
    logic [0:0]  r_resp;
    logic        aw_valid, aw_ready;
    logic [3:0]  aw_address;
    logic        w_valid, w_ready;
    logic [31:0] w_data;
    logic        b_valid, b_ready;
    logic [0:0]  b_resp;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Memory model controls
    int   ar_wait = 0, aw_wait = 0, w_wait = 0;
    logic force_err = 1'b0;
    int   ar_cnt, aw_cnt, w_cnt;
    logic got_aw, got_w;
    logic [3:0]  sl_awaddr;
    logic [31:0] sl_wdata;
    logic [31:0] mem [16];

    // Handshake monitor
    int aw_n = 0, w_n = 0, aw_c = 0, w_c = 0, b_first = -1;

    axi_lite_master dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .err_count(err_count),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_address(ar_address),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_address(aw_address),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign ar_ready = ar_valid && (ar_cnt == ar_wait);
    assign aw_ready = aw_valid && (aw_cnt == aw_wait);
    assign w_ready  = w_valid && (w_cnt == w_wait);
    assign r_resp   = force_err ? RESP_ERR : RESP_OKAY;
    assign b_resp   = force_err ? RESP_ERR : RESP_OKAY;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'hA000_0000 + 32'(i);
            ar_cnt <= 0; aw_cnt <= 0; w_cnt <= 0;
            r_valid <= 1'b0; r_data <= 32'h0; b_valid <= 1'b0;
            got_aw <= 1'b0; got_w <= 1'b0; sl_awaddr <= 4'h0; sl_wdata <= 32'h0;
        end else begin
            if (r_valid && r_ready) r_valid <= 1'b0;
            if (ar_valid && ar_ready) begin
                ar_cnt <= 0; r_valid <= 1'b1; r_data <= mem[ar_address];
            end else if (ar_valid) ar_cnt <= ar_cnt + 1;
            if (aw_valid && aw_ready) begin
                aw_cnt <= 0; got_aw <= 1'b1; sl_awaddr <= aw_address;
            end else if (aw_valid) aw_cnt <= aw_cnt + 1;
            if (w_valid && w_ready) begin
                w_cnt <= 0; got_w <= 1'b1; sl_wdata <= w_data;
            end else if (w_valid) w_cnt <= w_cnt + 1;
            if (b_valid && b_ready) b_valid <= 1'b0;
            if ((got_aw || (aw_valid && aw_ready)) && (got_w || (w_valid && w_ready))) begin
                mem[(aw_valid && aw_ready) ? aw_address : sl_awaddr] <=
                    (w_valid && w_ready) ? w_data : sl_wdata;
                b_valid <= 1'b1; got_aw <= 1'b0; got_w <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (aw_valid && aw_ready) begin aw_n++; aw_c = cyc; end
        if (w_valid && w_ready)   begin w_n++;  w_c = cyc;  end
        if (b_ready && b_first < 0) b_first = cyc;
    end

    // Drives one command and collects its response; no checking here.
    task automatic do_cmd(input logic wr, input logic [3:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic er, output int lat,
                          output int acc, output logic to);
        int n;
        to = 1'b0; rd = 32'h0; er = 1'b0; lat = 0; acc = 0;
        @(negedge clk);
        n = 0;
        while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
        if (!cmd_ready) begin to = 1'b1; return; end
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; acc = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
        if (!rsp_valid) begin to = 1'b1; return; end
        lat = cyc - acc; rd = rsp_rdata; er = rsp_err;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if ({ar_valid, aw_valid, w_valid, r_ready, b_ready, rsp_valid, cmd_ready} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b exp 0000000",
                     {ar_valid, aw_valid, w_valid, r_ready, b_ready, rsp_valid, cmd_ready});
        end
        n_tests++;
        if ({rsp_rdata, rsp_err, err_count, ar_address, aw_address, w_data} !== 81'b0) begin
            n_fail++;
            $display("FAIL reset_data: rdata %h err %b cnt %0d ar %h aw %h w %h exp all 0",
                     rsp_rdata, rsp_err, err_count, ar_address, aw_address, w_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_cmd_ready: got %b exp 1", cmd_ready);
        end
    endtask

    task automatic test_write_read();
        logic [31:0] rd; logic er, to; int lat, acc;
        do_cmd(1'b1, 4'h3, 32'hDEAD_BEEF, rd, er, lat, acc, to);
        n_tests++;
        if ({to, er, rd} !== 34'h0 || lat !== 3) begin
            n_fail++;
            $display("FAIL write_rsp: to %b err %b rdata %h lat %0d exp 0 0 00000000 3", to, er, rd, lat);
        end
        do_cmd(1'b0, 4'h3, 32'h0, rd, er, lat, acc, to);
        n_tests++;
        if (to !== 1'b0 || rd !== 32'hDEAD_BEEF || er !== 1'b0) begin
            n_fail++;
            $display("FAIL read_rsp: to %b rdata %h err %b exp 0 deadbeef 0", to, rd, er);
        end
        n_tests++;
        if (lat !== 3) begin
            n_fail++; $display("FAIL read_lat: got %0d exp 3", lat);
        end
    endtask

    task automatic test_aw_w_order();
        int aws[3] = '{2, 0, 1};
        int ws[3]  = '{0, 2, 1};
        logic [31:0] rd; logic er, to; int lat, acc, mx;
        for (int k = 0; k < 3; k++) begin
            aw_wait = aws[k]; w_wait = ws[k];
            mx = (aws[k] > ws[k]) ? aws[k] : ws[k];
            aw_n = 0; w_n = 0; b_first = -1;
            do_cmd(1'b1, 4'(8 + k), 32'h1111_0000 + 32'(k), rd, er, lat, acc, to);
            n_tests++;
            if (to !== 1'b0 || aw_n !== 1 || w_n !== 1) begin
                n_fail++;
                $display("FAIL order%0d_hs: to %b aw_hs %0d w_hs %0d exp 0 1 1", k, to, aw_n, w_n);
            end
            n_tests++;
            if (b_first - acc !== 2 + mx) begin
                n_fail++;
                $display("FAIL order%0d_wr_resp_cyc: got %0d exp %0d", k, b_first - acc, 2 + mx);
            end
            n_tests++;
            if (b_first !== ((aw_c > w_c) ? aw_c : w_c) + 1) begin
                n_fail++;
                $display("FAIL order%0d_after_last_hs: b_ready cyc %0d aw %0d w %0d", k, b_first, aw_c, w_c);
            end
            n_tests++;
            if (lat !== 3 + mx) begin
                n_fail++; $display("FAIL order%0d_lat: got %0d exp %0d", k, lat, 3 + mx);
            end
        end
        aw_wait = 0; w_wait = 0;
        do_cmd(1'b0, 4'h9, 32'h0, rd, er, lat, acc, to);
        n_tests++;
        if (rd !== 32'h1111_0001) begin
            n_fail++; $display("FAIL order_readback: got %h exp 11110001", rd);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er, to; int lat, acc, exp_cnt;
        force_err = 1'b1;
        for (int i = 0; i < 300; i++) begin
            do_cmd(1'b0, 4'(i), 32'h0, rd, er, lat, acc, to);
            exp_cnt = (i + 1 > 255) ? 255 : i + 1;
            n_tests++;
            if (to !== 1'b0 || er !== 1'b1) begin
                n_fail++; $display("FAIL err_rsp%0d: to %b err %b exp 0 1", i, to, er);
            end
            n_tests++;
            if (err_count !== 8'(exp_cnt)) begin
                n_fail++; $display("FAIL err_count%0d: got %0d exp %0d", i, err_count, exp_cnt);
            end
        end
        force_err = 1'b0;
    endtask

    task automatic test_backpressure();
        int acc, ar_cycles, bad_addr, bad_cr, n;
        logic [31:0] rd;
        ar_wait = 5; ar_cycles = 0; bad_addr = 0; bad_cr = 0;
        @(negedge clk);
        n_tests++;
        if (cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_idle_ready: got %b exp 1", cmd_ready);
        end
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h3; acc = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 50) begin
            if (ar_valid) begin
                ar_cycles++;
                if (ar_address !== 4'h3) bad_addr++;
            end
            if (cmd_ready !== 1'b0) bad_cr++;
            @(negedge clk); n++;
        end
        n_tests++;
        if (rsp_valid !== 1'b1 || cyc - acc !== 8) begin
            n_fail++; $display("FAIL bp_lat: valid %b lat %0d exp 1 8", rsp_valid, cyc - acc);
        end
        n_tests++;
        if (ar_cycles !== 6 || bad_addr !== 0 || bad_cr !== 0) begin
            n_fail++;
            $display("FAIL bp_ar: ar_cycles %0d bad_addr %0d bad_cmd_ready %0d exp 6 0 0",
                     ar_cycles, bad_addr, bad_cr);
        end
        rd = rsp_rdata;
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if ({rsp_valid, rsp_err, cmd_ready, rsp_rdata} !== {3'b100, 32'hDEAD_BEEF}) begin
                n_fail++;
                $display("FAIL bp_rsp_hold%0d: valid %b err %b cmd_ready %b rdata %h exp 1 0 0 deadbeef",
                         k, rsp_valid, rsp_err, cmd_ready, rsp_rdata);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        n_tests++;
        if ({rsp_valid, cmd_ready} !== 2'b01 || rd !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL bp_release: valid %b cmd_ready %b rdata %h exp 0 1 deadbeef",
                     rsp_valid, cmd_ready, rd);
        end
        ar_wait = 0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er, to; int lat, acc, seen;
        aw_wait = 0; w_wait = 5;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h5; cmd_wdata = 32'h1234_5678;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({aw_valid, w_valid} !== 2'b01) begin
            n_fail++; $display("FAIL mid_pre: aw_valid %b w_valid %b exp 0 1", aw_valid, w_valid);
        end
        rst_n = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({ar_valid, aw_valid, w_valid, r_ready, b_ready, rsp_valid, cmd_ready} !== 7'b0) begin
            n_fail++;
            $display("FAIL mid_reset_ctrl: got %b exp 0000000",
                     {ar_valid, aw_valid, w_valid, r_ready, b_ready, rsp_valid, cmd_ready});
        end
        n_tests++;
        if (err_count !== 8'd0) begin
            n_fail++; $display("FAIL mid_err_count: got %0d exp 0", err_count);
        end
        w_wait = 0;
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) seen++;
        end
        n_tests++;
        if (seen !== 0) begin
            n_fail++; $display("FAIL mid_no_rsp: rsp_valid cycles %0d exp 0", seen);
        end
        do_cmd(1'b0, 4'h0, 32'h0, rd, er, lat, acc, to);
        n_tests++;
        if (to !== 1'b0 || rd !== 32'hA000_0000 || er !== 1'b0 || lat !== 3) begin
            n_fail++;
            $display("FAIL mid_next_read: to %b rdata %h err %b lat %0d exp 0 a0000000 0 3",
                     to, rd, er, lat);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_aw_w_order();
        test_errors();
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
